// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals shared between the
// two requesters, the arbiter and the external combinational ALU.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OP_WIDTH   = 4,
  parameter int FLAG_WIDTH = 5
);
  // Request side
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [OP_WIDTH-1:0]   req0_op;
  logic [OP_WIDTH-1:0]   req1_op;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;

  // Shared ALU side
  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic                  alu_en;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [FLAG_WIDTH-1:0] alu_flags;

  // Response side
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic [FLAG_WIDTH-1:0] rsp_flags;
  logic                  rsp_err;

  // Arbiter view
  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    output req_ready,
    output alu_op, alu_a, alu_b, alu_en,
    input  alu_result, alu_flags,
    output rsp_valid, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready
  );

  // Requester / ALU environment view
  modport master (
    output req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    input  req_ready,
    input  alu_op, alu_a, alu_b, alu_en,
    output alu_result, alu_flags,
    input  rsp_valid, rsp_result, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational
// ALU. One operation in flight at a time: IDLE (arbitrate/accept),
// ISSUE (ALU sampled), RESP (response held until consumed).
module alu_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int OP_WIDTH   = 4,
  parameter int FLAG_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [OP_WIDTH-1:0] {
    ALU_OP_ADD  = OP_WIDTH'(0),
    ALU_OP_SUB  = OP_WIDTH'(1),
    ALU_OP_AND  = OP_WIDTH'(2),
    ALU_OP_OR   = OP_WIDTH'(3),
    ALU_OP_XOR  = OP_WIDTH'(4),
    ALU_OP_NAND = OP_WIDTH'(5),
    ALU_OP_NOR  = OP_WIDTH'(6),
    ALU_OP_XNOR = OP_WIDTH'(7),
    ALU_OP_SHL  = OP_WIDTH'(8),
    ALU_OP_SHR  = OP_WIDTH'(9),
    ALU_OP_NOT  = OP_WIDTH'(10)
  } enum_alu_opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  logic                  last_grant;
  logic                  grant;
  logic                  arb_idx;
  logic                  accept;
  logic                  release_rsp;
  logic                  op_legal;

  logic [OP_WIDTH-1:0]   cap_op;
  logic [DATA_WIDTH-1:0] cap_a;
  logic [DATA_WIDTH-1:0] cap_b;

  logic [1:0]            req_ready_c;
  logic [1:0]            rsp_valid_c;
  logic                  alu_en_c;

  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic [FLAG_WIDTH-1:0] rsp_flags_q;
  logic                  rsp_err_q;

  // Winner among pending requests: a lone request wins outright, a tie
  // goes to the requester that was not served last.
  always_comb begin
    arb_idx = bus.req_valid[1];
    if (&bus.req_valid) begin
      arb_idx = ~last_grant;
    end
  end

  // Opcodes above the last defined ALU operation are rejected.
  always_comb begin
    op_legal = (cap_op <= ALU_OP_NOT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next  = state;
    req_ready_c = '0;
    rsp_valid_c = '0;
    alu_en_c    = 1'b0;
    accept      = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (|bus.req_valid)) begin
          req_ready_c[arb_idx] = 1'b1;
          accept               = 1'b1;
          state_next           = ISSUE;
        end
      end
      ISSUE: begin
        alu_en_c   = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid_c[grant] = 1'b1;
        if (bus.rsp_ready[grant]) begin
          release_rsp = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, response payload and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      cap_op       <= '0;
      cap_a        <= '0;
      cap_b        <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        grant <= arb_idx;
        if (arb_idx) begin
          cap_op <= bus.req1_op;
          cap_a  <= bus.req1_a;
          cap_b  <= bus.req1_b;
        end else begin
          cap_op <= bus.req0_op;
          cap_a  <= bus.req0_a;
          cap_b  <= bus.req0_b;
        end
      end
      if (state == ISSUE) begin
        if (op_legal) begin
          rsp_result_q <= bus.alu_result;
          rsp_flags_q  <= bus.alu_flags;
          rsp_err_q    <= 1'b0;
        end else begin
          rsp_result_q <= '0;
          rsp_flags_q  <= '0;
          rsp_err_q    <= 1'b1;
        end
      end
      if (release_rsp) begin
        last_grant <= grant;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.alu_en     = alu_en_c;
  assign bus.alu_op     = cap_op;
  assign bus.alu_a      = cap_a;
  assign bus.alu_b      = cap_b;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int unsigned errors;
  int unsigned checks;

  alu_arbiter_if #(.DATA_WIDTH(16), .OP_WIDTH(4), .FLAG_WIDTH(5)) bus ();

  alu_arbiter #(.DATA_WIDTH(16), .OP_WIDTH(4), .FLAG_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: flags {carry, zero, equal, larger, lower}; compare
  // flags only from SUB; undefined opcodes return junk so rejection shows.
  logic [16:0] alu_wide;
  always_comb begin
    alu_wide       = '0;
    bus.alu_result = 16'hDEAD;
    bus.alu_flags  = 5'b11111;
    case (bus.alu_op)
      4'd0: begin
        alu_wide       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = alu_wide[15:0];
        bus.alu_flags  = {alu_wide[16], alu_wide[15:0] == 16'h0, 3'b000};
      end
      4'd1: begin
        alu_wide       = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        bus.alu_result = alu_wide[15:0];
        bus.alu_flags  = {alu_wide[16], alu_wide[15:0] == 16'h0,
                          bus.alu_a == bus.alu_b, bus.alu_a > bus.alu_b,
                          bus.alu_a < bus.alu_b};
      end
      4'd2: begin
        bus.alu_result = bus.alu_a & bus.alu_b;
        bus.alu_flags  = {1'b0, (bus.alu_a & bus.alu_b) == 16'h0, 3'b000};
      end
      default: begin
        bus.alu_result = 16'hDEAD;
        bus.alu_flags  = 5'b11111;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req0_op = 4'd0; bus.req0_a = 16'h0; bus.req0_b = 16'h0;
    bus.req1_op = 4'd0; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
    tick();
    tick();

    // Reset state, including pending requests ignored while rst is high
    bus.req_valid = 2'b11;
    settle();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_alu_en", 32'(bus.alu_en), 32'h0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'h0);
    chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    bus.req_valid = 2'b00;
    tick();
    rst = 1'b0;

    // Single request: req0 ADD 3+4
    bus.req0_op = 4'd0; bus.req0_a = 16'h0003; bus.req0_b = 16'h0004;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    settle();
    chk("single_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    settle();
    chk("single_alu_en", 32'(bus.alu_en), 32'h1);
    chk("single_alu_a", 32'(bus.alu_a), 32'h3);
    chk("single_alu_b", 32'(bus.alu_b), 32'h4);
    chk("single_rsp_valid_issue", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_result", 32'(bus.rsp_result), 32'h7);
    chk("single_flags", 32'(bus.rsp_flags), 32'h0);
    chk("single_err", 32'(bus.rsp_err), 32'h0);
    chk("single_alu_en_resp", 32'(bus.alu_en), 32'h0);
    tick();
    chk("single_rsp_valid_clear", 32'(bus.rsp_valid), 32'h0);

    // Reset again so the following tie starts from fresh history
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Tie after reset: req0 SUB 5-5 wins, then req1 ADD 1+1
    bus.req0_op = 4'd1; bus.req0_a = 16'h0005; bus.req0_b = 16'h0005;
    bus.req1_op = 4'd0; bus.req1_a = 16'h0001; bus.req1_b = 16'h0001;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    settle();
    chk("tie_first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b10;
    settle();
    chk("tie_no_accept_issue", 32'(bus.req_ready), 32'h0);
    tick();
    chk("tie_rsp0_valid", 32'(bus.rsp_valid), 32'h1);
    chk("tie_rsp0_result", 32'(bus.rsp_result), 32'h0);
    chk("tie_rsp0_flags", 32'(bus.rsp_flags), 32'h0C);
    chk("tie_no_accept_resp", 32'(bus.req_ready), 32'h0);
    tick();
    chk("tie_second_grant", 32'(bus.req_ready), 32'h2);
    tick();
    tick();
    bus.req_valid = 2'b00;
    settle();
    chk("tie_rsp1_valid", 32'(bus.rsp_valid), 32'h2);
    chk("tie_rsp1_result", 32'(bus.rsp_result), 32'h2);
    chk("tie_rsp1_flags", 32'(bus.rsp_flags), 32'h0);
    tick();

    // Backpressure: req0 ADD FFFF+1, consumer stalls 4 cycles; the other
    // requester's rsp_ready must not release it
    bus.req0_op = 4'd0; bus.req0_a = 16'hFFFF; bus.req0_b = 16'h0001;
    bus.req1_op = 4'hF; bus.req1_a = 16'h1234; bus.req1_b = 16'h5678;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b10;
    settle();
    chk("bp_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b11;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_result", 32'(bus.rsp_result), 32'h0);
      chk("bp_flags", 32'(bus.rsp_flags), 32'h18);
      chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    chk("bp_still_held", 32'(bus.rsp_valid), 32'h1);
    bus.rsp_ready = 2'b01;
    tick();
    chk("bp_released", 32'(bus.rsp_valid), 32'h0);
    chk("bp_rr_grant_req1", 32'(bus.req_ready), 32'h2);

    // Illegal opcode 0xF from req1 (accepted at the edge just ahead)
    tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b10;
    settle();
    chk("ill_alu_en", 32'(bus.alu_en), 32'h1);
    chk("ill_alu_op", 32'(bus.alu_op), 32'hF);
    tick();
    chk("ill_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("ill_result", 32'(bus.rsp_result), 32'h0);
    chk("ill_flags", 32'(bus.rsp_flags), 32'h0);
    chk("ill_err", 32'(bus.rsp_err), 32'h1);
    tick();
    chk("ill_released", 32'(bus.rsp_valid), 32'h0);

    // req0 ADD 2+2 completes, leaving req0 as last served
    bus.req0_op = 4'd0; bus.req0_a = 16'h0002; bus.req0_b = 16'h0002;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    settle();
    chk("pre_rst_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("pre_rst_result", 32'(bus.rsp_result), 32'h4);
    chk("pre_rst_err", 32'(bus.rsp_err), 32'h0);
    tick();

    // req0 ADD 6+7 in flight, reset pulse while response is held
    bus.req0_a = 16'h0006; bus.req0_b = 16'h0007;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("mid_result", 32'(bus.rsp_result), 32'hD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 2'b11;
    settle();
    chk("rstresp_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rstresp_result", 32'(bus.rsp_result), 32'h0);
    chk("rstresp_alu_a", 32'(bus.alu_a), 32'h0);
    chk("rstresp_alu_en", 32'(bus.alu_en), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstresp_no_late_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    bus.req_valid = 2'b11;
    settle();
    chk("rstresp_tie_req0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
